// File: rtl/puck_pkg.sv
// Shared puck/table definitions: controller state encoding, table geometry
// defaults (also used by the renderer and mallet logic) and velocity helpers.
package puck_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GOAL = 2'd2
    } puck_state_t;

    localparam int TABLE_X_MIN      = 32;
    localparam int TABLE_X_MAX      = 991;
    localparam int TABLE_Y_MIN      = 32;
    localparam int TABLE_Y_MAX      = 735;
    localparam int TABLE_GOAL_Y_MIN = 304;
    localparam int TABLE_GOAL_Y_MAX = 463;
    localparam int TABLE_SERVE_X    = 512;
    localparam int TABLE_SERVE_Y    = 384;
    localparam int PUCK_RADIUS      = 20;
    localparam int PUCK_VMAX        = 15;

    function automatic logic signed [7:0] sat_vel(input logic signed [7:0] v,
                                                  input logic signed [7:0] lim);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

    // One friction step: magnitude drops by 1, zero stays zero.
    function automatic logic signed [7:0] decay_vel(input logic signed [7:0] v);
        if (v > 8'sd0)
            return v - 8'sd1;
        else if (v < 8'sd0)
            return v + 8'sd1;
        else
            return v;
    endfunction

endpackage

// File: rtl/vblnk_edge.sv
// Frame tick generator: one-cycle pulse on the rising edge of vertical blank.
module vblnk_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic vblnk_in,
    output logic tick
);

    logic vblnk_d;

    always_ff @(posedge clk_in) begin
        if (rst)
            vblnk_d <= 1'b0;
        else
            vblnk_d <= vblnk_in;
    end

    assign tick = vblnk_in & ~vblnk_d;

endmodule

// File: rtl/puck_motion_ctl.sv
// Per-frame puck position controller: integrates velocity, friction, wall
// reflection and goal/serve sequencing, updating position only on frame ticks.
module puck_motion_ctl
    import puck_pkg::*;
#(
    parameter int X_MIN           = TABLE_X_MIN,
    parameter int X_MAX           = TABLE_X_MAX,
    parameter int Y_MIN           = TABLE_Y_MIN,
    parameter int Y_MAX           = TABLE_Y_MAX,
    parameter int GOAL_Y_MIN      = TABLE_GOAL_Y_MIN,
    parameter int GOAL_Y_MAX      = TABLE_GOAL_Y_MAX,
    parameter int SERVE_X         = TABLE_SERVE_X,
    parameter int SERVE_Y         = TABLE_SERVE_Y,
    parameter int RADIUS          = PUCK_RADIUS,
    parameter int VMAX            = PUCK_VMAX,
    parameter int FRICTION_FRAMES = 8,
    parameter int SERVE_DELAY     = 60
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              vblnk_in,
    input  logic              start,
    input  logic              hit_valid,
    input  logic signed [7:0] hit_vx,
    input  logic signed [7:0] hit_vy,
    output logic [11:0]       xpos,
    output logic [11:0]       ypos,
    output logic              playing,
    output logic              goal_left,
    output logic              goal_right,
    output puck_state_t       state_dbg
);

    localparam logic signed [13:0] X_LO_WALL = 14'(X_MIN + RADIUS);
    localparam logic signed [13:0] X_HI_WALL = 14'(X_MAX - RADIUS);
    localparam logic signed [13:0] Y_LO_WALL = 14'(Y_MIN + RADIUS);
    localparam logic signed [13:0] Y_HI_WALL = 14'(Y_MAX - RADIUS);
    localparam logic signed [13:0] X_GOAL_LO = 14'(X_MIN);
    localparam logic signed [13:0] X_GOAL_HI = 14'(X_MAX);
    localparam logic [11:0]        MOUTH_LO  = 12'(GOAL_Y_MIN);
    localparam logic [11:0]        MOUTH_HI  = 12'(GOAL_Y_MAX);
    localparam logic [11:0]        SERVE_XP  = 12'(SERVE_X);
    localparam logic [11:0]        SERVE_YP  = 12'(SERVE_Y);
    localparam logic signed [7:0]  VLIM      = 8'(VMAX);
    localparam logic [15:0]        FRIC_N    = 16'(FRICTION_FRAMES);
    localparam logic [15:0]        DELAY_N   = 16'(SERVE_DELAY);

    puck_state_t       state, state_n;
    logic [11:0]       x_n, y_n;
    logic signed [7:0] vx, vy, vx_n, vy_n;
    logic [15:0]       cnt, cnt_n, cnt_inc;
    logic              pend, pend_n;
    logic signed [7:0] lx, ly, lx_n, ly_n;
    logic              gl_n, gr_n;
    logic              tick;

    logic signed [7:0]  hvx, hvy, fvx, fvy, wvx, wvy;
    logic               use_hit, fric_due, mouth, goal_l, goal_r;
    logic signed [13:0] nx, ny;
    logic [11:0]        wx, wy;

    vblnk_edge u_vblnk (
        .clk_in   (clk_in),
        .rst      (rst),
        .vblnk_in (vblnk_in),
        .tick     (tick)
    );

    // hit_valid is a strobe with no ready: always accepted in PLAY (latest wins
    // until the next tick), silently dropped in IDLE and GOAL.
    always_comb begin
        hvx      = sat_vel(hit_vx, VLIM);
        hvy      = sat_vel(hit_vy, VLIM);
        use_hit  = hit_valid | pend;
        cnt_inc  = (use_hit ? 16'd0 : cnt) + 16'd1;
        fric_due = (FRIC_N != 16'd0) && (cnt_inc == FRIC_N);
        fvx      = vx;
        fvy      = vy;
        if (use_hit) begin
            fvx = hit_valid ? hvx : lx;
            fvy = hit_valid ? hvy : ly;
        end else if (fric_due) begin
            fvx = decay_vel(vx);
            fvy = decay_vel(vy);
        end
        nx    = $signed({2'b00, xpos}) + $signed({{6{fvx[7]}}, fvx});
        ny    = $signed({2'b00, ypos}) + $signed({{6{fvy[7]}}, fvy});
        mouth = (ypos >= MOUTH_LO) && (ypos <= MOUTH_HI);
        wx    = nx[11:0];
        wy    = ny[11:0];
        wvx   = fvx;
        wvy   = fvy;
        if (ny < Y_LO_WALL) begin
            wy  = Y_LO_WALL[11:0];
            wvy = -fvy;
        end else if (ny > Y_HI_WALL) begin
            wy  = Y_HI_WALL[11:0];
            wvy = -fvy;
        end
        // Inside the goal mouth the side walls are open.
        if (!mouth && nx < X_LO_WALL) begin
            wx  = X_LO_WALL[11:0];
            wvx = -fvx;
        end else if (!mouth && nx > X_HI_WALL) begin
            wx  = X_HI_WALL[11:0];
            wvx = -fvx;
        end
        goal_l = mouth && (nx < X_GOAL_LO);
        goal_r = mouth && (nx > X_GOAL_HI);
    end

    always_comb begin
        state_n = state;
        x_n     = xpos;
        y_n     = ypos;
        vx_n    = vx;
        vy_n    = vy;
        cnt_n   = cnt;
        pend_n  = pend;
        lx_n    = lx;
        ly_n    = ly;
        gl_n    = 1'b0;
        gr_n    = 1'b0;
        unique case (state)
            S_IDLE: begin
                pend_n = 1'b0;
                if (start) begin
                    state_n = S_PLAY;
                    vx_n    = 8'sd0;
                    vy_n    = 8'sd0;
                    cnt_n   = 16'd0;
                end
            end
            S_PLAY: begin
                if (hit_valid) begin
                    pend_n = 1'b1;
                    lx_n   = hvx;
                    ly_n   = hvy;
                end
                if (tick) begin
                    pend_n = 1'b0;
                    if (goal_l || goal_r) begin
                        gl_n    = goal_l;
                        gr_n    = goal_r;
                        cnt_n   = 16'd0;
                        state_n = S_GOAL;
                    end else begin
                        x_n   = wx;
                        y_n   = wy;
                        vx_n  = wvx;
                        vy_n  = wvy;
                        cnt_n = (FRIC_N == 16'd0 || fric_due) ? 16'd0 : cnt_inc;
                    end
                end
            end
            S_GOAL: begin
                pend_n = 1'b0;
                if (tick) begin
                    if (cnt + 16'd1 == DELAY_N) begin
                        x_n     = SERVE_XP;
                        y_n     = SERVE_YP;
                        vx_n    = 8'sd0;
                        vy_n    = 8'sd0;
                        cnt_n   = 16'd0;
                        state_n = S_PLAY;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= S_IDLE;
            xpos       <= SERVE_XP;
            ypos       <= SERVE_YP;
            vx         <= 8'sd0;
            vy         <= 8'sd0;
            cnt        <= 16'd0;
            pend       <= 1'b0;
            lx         <= 8'sd0;
            ly         <= 8'sd0;
            goal_left  <= 1'b0;
            goal_right <= 1'b0;
        end else begin
            state      <= state_n;
            xpos       <= x_n;
            ypos       <= y_n;
            vx         <= vx_n;
            vy         <= vy_n;
            cnt        <= cnt_n;
            pend       <= pend_n;
            lx         <= lx_n;
            ly         <= ly_n;
            goal_left  <= gl_n;
            goal_right <= gr_n;
        end
    end

    assign playing   = (state == S_PLAY);
    assign state_dbg = state;

endmodule

// File: doc/puck_motion_ctl.md
Name: puck_motion_ctl

Overview:
- Per-frame position controller for the puck circle renderer.
- Owns the puck xpos/ypos registers and updates them once per frame, on the rising edge of vertical blank, so the pixel pipeline never sees coordinates change mid-frame.
- Integrates velocity, applies friction, reflects off table walls, detects goals and sequences serve/restart.
- Sits between game logic (mallet-hit events) and the circle drawing stage of the VGA pipeline.

Parameters:
- X_MIN, 32, left table edge (px)
- X_MAX, 991, right table edge (px)
- Y_MIN, 32, top table edge (px)
- Y_MAX, 735, bottom table edge (px)
- GOAL_Y_MIN, 304, goal mouth upper y (inclusive)
- GOAL_Y_MAX, 463, goal mouth lower y (inclusive)
- SERVE_X, 512, serve/reset x position
- SERVE_Y, 384, serve/reset y position
- RADIUS, 20, puck radius (px); must match the renderer
- VMAX, 15, velocity saturation magnitude (px/frame)
- FRICTION_FRAMES, 8, frames between friction decrements; 0 disables friction
- SERVE_DELAY, 60, frames frozen after a goal

Ports:
- clk_in  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vblnk_in  in  1  vertical blank from timing chain
- start  in  1  one-cycle pulse; leaves IDLE
- hit_valid  in  1  one-cycle mallet-hit strobe
- hit_vx  in  8  signed new x velocity
- hit_vy  in  8  signed new y velocity
- xpos  out  12  puck centre x
- ypos  out  12  puck centre y
- playing  out  1  high in PLAY
- goal_left  out  1  one-cycle pulse: puck entered the left goal
- goal_right  out  1  one-cycle pulse: puck entered the right goal

Behaviour:
- Clocking and reset: single clock clk_in; rst is synchronous, active-high.
- Reset state: xpos=SERVE_X, ypos=SERVE_Y, vx=vy=0, playing=0, goal_*=0, state=IDLE, all counters 0, hit latch cleared.
- Frame tick:
  - vblnk_d is a registered copy of vblnk_in.
  - tick = vblnk_in & ~vblnk_d.
  - All position/velocity updates occur at the clock edge ending the tick cycle, so outputs change 1 cycle after vblnk_in rises and are constant otherwise.
- Hit latch:
  - hit_valid in any cycle stores the hit, saturating each component to [-VMAX, +VMAX].
  - A later hit before the next tick overwrites the stored hit.
  - A hit coinciding with the tick cycle is used at that tick.
  - The latch clears when consumed.
  - Hits in IDLE or GOAL are discarded.
- FSM IDLE: position held at serve. start moves the FSM to PLAY on the next edge, with v=0.
- FSM PLAY, on each tick:
  - Velocity update: if a hit is latched, v = latched hit; else apply friction.
  - Position: nx = xpos+vx, ny = ypos+vy, computed as 14-bit signed.
  - Y walls:
    - ny < Y_MIN+RADIUS → ypos = Y_MIN+RADIUS, vy = -vy.
    - ny > Y_MAX-RADIUS → ypos = Y_MAX-RADIUS, vy = -vy.
  - X walls, with mouth = current ypos in [GOAL_Y_MIN, GOAL_Y_MAX]:
    - Not mouth and nx < X_MIN+RADIUS → xpos = X_MIN+RADIUS, vx = -vx.
    - Not mouth and nx > X_MAX-RADIUS → xpos = X_MAX-RADIUS, vx = -vx.
    - Mouth and nx < X_MIN → goal_left pulse, position unchanged, go to GOAL.
    - Mouth and nx > X_MAX → goal_right pulse, position unchanged, go to GOAL.
    - Mouth and within the walls → free motion, no clamp.
- Friction:
  - A frame counter counts ticks in PLAY.
  - When the count reaches FRICTION_FRAMES, |vx| and |vy| each drop by 1 toward 0 (0 stays 0) and the counter clears.
  - A hit also clears the counter.
- FSM GOAL:
  - playing=0; the frame counter counts ticks.
  - At the SERVE_DELAY-th tick: xpos=SERVE_X, ypos=SERVE_Y, v=0, go to PLAY.
- Widths:
  - Velocity is held as 8-bit signed, always within ±VMAX.
  - Negation of -VMAX is safe since VMAX ≤ 127.
  - No 12-bit wrap is possible because clamps always apply first.
- Reset mid-operation (any state) returns to the reset state on the next edge. A pending hit or goal pulse is dropped.

Decomposition:
- Shared package puck_pkg:
  - FSM state encoding (IDLE, PLAY, GOAL).
  - Table geometry defaults, shared with the renderer and mallet logic.
  - VMAX.
- One sub-module, vblnk_edge: registers vblnk_in and emits tick. It is reused by other per-frame controllers.

Test Plan:
- Bench uses FRICTION_FRAMES=0 unless stated.
- Reset then 3 frames without start → xpos=512, ypos=384, playing=0, no goal pulses.
- start, hit vx=+5 vy=0, 1 frame → xpos=517, one cycle after vblnk_in rise; unchanged for the rest of the frame.
- start, hit vx=0 vy=-15 → ypos=54 after 22 ticks, 52 after tick 23 (vy=+15), 67 after tick 24.
- start, hit vx=-15 at y=384 → xpos=32 after tick 32, goal_left single-cycle pulse at tick 33, xpos held. After 60 more ticks: 512/384, v=0, playing=1.
- hit_vx=+100 → effective vx=+15. With FRICTION_FRAMES=8, vx=14 after tick 8 and 0 after tick 120.
- rst asserted mid-PLAY with hit latched → next cycle: reset values, IDLE. The pending hit has no effect after start.
